cursor_navegador: RTL and testbench

CURSOR_NAVEGADOR -- requirements
Module: cursor_navegador

---
 rtl/cursor_navegador.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cursor_navegador.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_navegador.sv
// cursor_navegador
// Moves a text cursor over a COLS x ROWS grid from debounced push-button
// levels. A rising edge on a direction button moves the cursor one cell.
// Moves wrap between rows for izq/der and saturate at the grid corners
// and at the top and bottom rows.
//
// Optional feature (macro CURSOR_AUTO_REPEAT_EN): holding a direction
// button auto-repeats the move. The first repeat comes after REPEAT_DELAY
// cycles and each later one after REPEAT_RATE cycles. Without the macro,
// every press gives exactly one move.
//
// Ports:
//   clk_100Mhz   in   single clock, rising edge
//   reset        in   synchronous, active-high
//   boton_arriba/abajo/izq/der/elige  in  filtered button levels
//   cursor_fila  out  [ROW_W-1:0]  current row (registered)
//   cursor_col   out  [COL_W-1:0]  current column (registered)
//   dir_lineal   out  [ROW_W+COL_W-1:0]  fila*COLS+col (registered)
//   mov_pulse    out  one-cycle strobe when a new cursor value appears
//   elige_pulse  out  one-cycle strobe per boton_elige rising edge
module cursor_navegador #(
  parameter int COLS         = 32,
  parameter int ROWS         = 16,
  parameter int COL_W        = 5,
  parameter int ROW_W        = 4,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                   clk_100Mhz,
  input  logic                   reset,
  input  logic                   boton_arriba,
  input  logic                   boton_abajo,
  input  logic                   boton_izq,
  input  logic                   boton_der,
  input  logic                   boton_elige,
  output logic [ROW_W-1:0]       cursor_fila,
  output logic [COL_W-1:0]       cursor_col,
  output logic [ROW_W+COL_W-1:0] dir_lineal,
  output logic                   mov_pulse,
  output logic                   elige_pulse
);

  localparam int LIN_W = ROW_W + COL_W;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1'b1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1'b1);

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  // Button bit order: 0 arriba, 1 abajo, 2 izq, 3 der, 4 elige
  logic [4:0]       btn_s, prev_r, rise_s;
  logic             edge_valid_s;
  dir_t             edge_dir_s;
  logic             req_r;        // move request, applied one cycle later
  dir_t             req_dir_r;
  logic             elige_req_r;
  logic [ROW_W-1:0] row_r, nxt_row_s;
  logic [COL_W-1:0] col_r, nxt_col_s;
  logic [LIN_W-1:0] lin_r, nxt_lin_s;
  logic             moved_s, mov_r, elige_r;

  assign btn_s  = {boton_elige, boton_der, boton_izq, boton_abajo, boton_arriba};
  assign rise_s = btn_s & ~prev_r;

  // Edge-detect flops plus the elige request stage
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      prev_r      <= 5'b0_0000;
      elige_req_r <= 1'b0;
    end else begin
      prev_r      <= btn_s;
      elige_req_r <= rise_s[4];
    end
  end

  // Priority encode direction edges: arriba > abajo > izq > der
  always_comb begin
    edge_valid_s = 1'b0;
    edge_dir_s   = DIR_UP;
    if (rise_s[0]) begin
      edge_valid_s = 1'b1;
      edge_dir_s   = DIR_UP;
    end else if (rise_s[1]) begin
      edge_valid_s = 1'b1;
      edge_dir_s   = DIR_DOWN;
    end else if (rise_s[2]) begin
      edge_valid_s = 1'b1;
      edge_dir_s   = DIR_LEFT;
    end else if (rise_s[3]) begin
      edge_valid_s = 1'b1;
      edge_dir_s   = DIR_RIGHT;
    end else begin
      edge_valid_s = 1'b0;
      edge_dir_s   = DIR_UP;
    end
  end

`ifdef CURSOR_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} state_t;

  state_t      state_r;
  dir_t        hold_dir_r;
  logic [31:0] cnt_r, cnt_inc_s;
  logic        held_s;

  function automatic logic level_of(input dir_t d, input logic [4:0] b);
    case (d)
      DIR_UP:    level_of = b[0];
      DIR_DOWN:  level_of = b[1];
      DIR_LEFT:  level_of = b[2];
      DIR_RIGHT: level_of = b[3];
      default:   level_of = 1'b0;
    endcase
  endfunction

  assign held_s    = level_of(hold_dir_r, btn_s);
  // Counter saturates instead of wrapping
  assign cnt_inc_s = (cnt_r == 32'hFFFF_FFFF) ? cnt_r : cnt_r + 32'd1;

  // Hold/repeat FSM; other direction edges are ignored outside IDLE
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_dir_r <= DIR_UP;
      cnt_r      <= 32'd0;
      req_r      <= 1'b0;
      req_dir_r  <= DIR_UP;
    end else begin
      req_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 32'd0;
          if (edge_valid_s) begin
            state_r    <= HOLD_WAIT;
            hold_dir_r <= edge_dir_s;
            req_r      <= 1'b1;
            req_dir_r  <= edge_dir_s;
          end
        end
        HOLD_WAIT: begin
          if (!held_s) begin
            state_r <= IDLE;
            cnt_r   <= 32'd0;
          end else if (cnt_r >= 32'(REPEAT_DELAY - 1)) begin
            state_r   <= REPEAT;
            cnt_r     <= 32'd0;
            req_r     <= 1'b1;
            req_dir_r <= hold_dir_r;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        REPEAT: begin
          if (!held_s) begin
            state_r <= IDLE;
            cnt_r   <= 32'd0;
          end else if (cnt_r >= 32'(REPEAT_RATE - 1)) begin
            cnt_r     <= 32'd0;
            req_r     <= 1'b1;
            req_dir_r <= hold_dir_r;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 32'd0;
        end
      endcase
    end
  end
`else
  // Edge-only mode: each accepted edge becomes one move request
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      req_r     <= 1'b0;
      req_dir_r <= DIR_UP;
    end else begin
      req_r     <= edge_valid_s;
      req_dir_r <= edge_dir_s;
    end
  end
`endif

  // Next cursor position; saturated requests leave moved_s low
  always_comb begin
    nxt_row_s = row_r;
    nxt_col_s = col_r;
    moved_s   = 1'b0;
    if (req_r) begin
      case (req_dir_r)
        DIR_UP: begin
          if (row_r != {ROW_W{1'b0}}) begin
            nxt_row_s = row_r - ROW_ONE;
            moved_s   = 1'b1;
          end else begin
            moved_s = 1'b0;
          end
        end
        DIR_DOWN: begin
          if (row_r != ROW_MAX) begin
            nxt_row_s = row_r + ROW_ONE;
            moved_s   = 1'b1;
          end else begin
            moved_s = 1'b0;
          end
        end
        DIR_LEFT: begin
          if (col_r != {COL_W{1'b0}}) begin
            nxt_col_s = col_r - COL_ONE;
            moved_s   = 1'b1;
          end else if (row_r != {ROW_W{1'b0}}) begin
            nxt_col_s = COL_MAX;
            nxt_row_s = row_r - ROW_ONE;
            moved_s   = 1'b1;
          end else begin
            moved_s = 1'b0;
          end
        end
        DIR_RIGHT: begin
          if (col_r != COL_MAX) begin
            nxt_col_s = col_r + COL_ONE;
            moved_s   = 1'b1;
          end else if (row_r != ROW_MAX) begin
            nxt_col_s = {COL_W{1'b0}};
            nxt_row_s = row_r + ROW_ONE;
            moved_s   = 1'b1;
          end else begin
            moved_s = 1'b0;
          end
        end
        default: moved_s = 1'b0;
      endcase
    end else begin
      moved_s = 1'b0;
    end
  end

  // Linear address is derived from the next position so it is coherent with row/col
  assign nxt_lin_s = LIN_W'(nxt_row_s) * LIN_W'(COLS) + LIN_W'(nxt_col_s);

  // Registered cursor state and output strobes
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      row_r   <= {ROW_W{1'b0}};
      col_r   <= {COL_W{1'b0}};
      lin_r   <= {LIN_W{1'b0}};
      mov_r   <= 1'b0;
      elige_r <= 1'b0;
    end else begin
      row_r   <= nxt_row_s;
      col_r   <= nxt_col_s;
      lin_r   <= nxt_lin_s;
      mov_r   <= moved_s;
      elige_r <= elige_req_r;
    end
  end

  assign cursor_fila = row_r;
  assign cursor_col  = col_r;
  assign dir_lineal  = lin_r;
  assign mov_pulse   = mov_r;
  assign elige_pulse = elige_r;

endmodule

// File: tb/tb_cursor_navegador.sv
// Directed bench for cursor_navegador with a 4x3 grid, REPEAT_DELAY=8 and REPEAT_RATE=4.
// The hold scenario expectations follow CURSOR_AUTO_REPEAT_EN.
module tb_cursor_navegador;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn = 5'b0_0000;  // 0 arriba, 1 abajo, 2 izq, 3 der, 4 elige
  logic [1:0] cursor_fila;
  logic [1:0] cursor_col;
  logic [3:0] dir_lineal;
  logic       mov_pulse;
  logic       elige_pulse;
  logic [8:0] obs;              // {fila, col, lin, mov}
  int         total = 0;
  int         bad = 0;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, ELIGE = 4;

  cursor_navegador #(
    .COLS(4), .ROWS(3), .COL_W(2), .ROW_W(2), .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut (
    .clk_100Mhz  (clk),
    .reset       (reset),
    .boton_arriba(btn[0]),
    .boton_abajo (btn[1]),
    .boton_izq   (btn[2]),
    .boton_der   (btn[3]),
    .boton_elige (btn[4]),
    .cursor_fila (cursor_fila),
    .cursor_col  (cursor_col),
    .dir_lineal  (dir_lineal),
    .mov_pulse   (mov_pulse),
    .elige_pulse (elige_pulse)
  );

  assign obs = {cursor_fila, cursor_col, dir_lineal, mov_pulse};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn   = 5'b0_0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One-cycle press; afterwards the result of the move is on the outputs
  task automatic pulse(input int b);
    btn[b] = 1'b1;
    tick();
    btn[b] = 1'b0;
    tick();
  endtask

  task automatic goto_lin(input int n);
    do_reset();
    for (int i = 0; i < n; i++) pulse(RIGHT);
    tick();
  endtask

  task automatic test_reset();
    btn   = 5'b0_0000;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({obs, elige_pulse} !== {2'd0, 2'd0, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {obs, elige_pulse}, 10'h000);
    end
    reset = 1'b0;
  endtask

  task automatic test_der();
    do_reset();
    btn[RIGHT] = 1'b1;
    tick();
    btn[RIGHT] = 1'b0;
    total++;
    if (obs !== {2'd0, 2'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL der_latency got=%h want=%h", obs, 9'h000);
    end
    tick();
    total++;
    if (obs !== {2'd0, 2'd1, 4'd1, 1'b1}) begin
      bad++;
      $display("FAIL der_move got=%h want=%h", obs, {2'd0, 2'd1, 4'd1, 1'b1});
    end
    tick();
    total++;
    if (obs !== {2'd0, 2'd1, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL der_pulse_width got=%h want=%h", obs, {2'd0, 2'd1, 4'd1, 1'b0});
    end
  endtask

  task automatic test_wrap();
    goto_lin(3);
    pulse(RIGHT);
    total++;
    if (obs !== {2'd1, 2'd0, 4'd4, 1'b1}) begin
      bad++;
      $display("FAIL der_wrap got=%h want=%h", obs, {2'd1, 2'd0, 4'd4, 1'b1});
    end
    goto_lin(11);
    pulse(RIGHT);
    total++;
    if (obs !== {2'd2, 2'd3, 4'd11, 1'b0}) begin
      bad++;
      $display("FAIL der_corner got=%h want=%h", obs, {2'd2, 2'd3, 4'd11, 1'b0});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    pulse(LEFT);
    total++;
    if (obs !== {2'd0, 2'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL izq_origin got=%h want=%h", obs, 9'h000);
    end
    pulse(UP);
    total++;
    if (obs !== {2'd0, 2'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL arriba_top got=%h want=%h", obs, 9'h000);
    end
    goto_lin(4);
    pulse(LEFT);
    total++;
    if (obs !== {2'd0, 2'd3, 4'd3, 1'b1}) begin
      bad++;
      $display("FAIL izq_wrap got=%h want=%h", obs, {2'd0, 2'd3, 4'd3, 1'b1});
    end
    goto_lin(9);
    pulse(DOWN);
    total++;
    if (obs !== {2'd2, 2'd1, 4'd9, 1'b0}) begin
      bad++;
      $display("FAIL abajo_bottom got=%h want=%h", obs, {2'd2, 2'd1, 4'd9, 1'b0});
    end
    pulse(UP);
    total++;
    if (obs !== {2'd1, 2'd1, 4'd5, 1'b1}) begin
      bad++;
      $display("FAIL arriba_move got=%h want=%h", obs, {2'd1, 2'd1, 4'd5, 1'b1});
    end
  endtask

  task automatic test_priority();
    int moves;
    goto_lin(5);
    btn[UP]    = 1'b1;
    btn[RIGHT] = 1'b1;
    tick();
    btn = 5'b0_0000;
    moves = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mov_pulse === 1'b1) moves++;
    end
    total++;
    if (obs !== {2'd0, 2'd1, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL prio_pos got=%h want=%h", obs, {2'd0, 2'd1, 4'd1, 1'b0});
    end
    total++;
    if (moves !== 1) begin
      bad++;
      $display("FAIL prio_count got=%0d want=1", moves);
    end
  endtask

  task automatic test_hold();
    int exp_mov;
    do_reset();
    btn[RIGHT] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) btn[RIGHT] = 1'b0;
      tick();
`ifdef CURSOR_AUTO_REPEAT_EN
      exp_mov = (i == 1 || i == 9 || i == 13 || i == 17) ? 1 : 0;
`else
      exp_mov = (i == 1) ? 1 : 0;
`endif
      total++;
      if (mov_pulse !== exp_mov[0]) begin
        bad++;
        $display("FAIL hold_cycle%0d got=%b want=%b", i, mov_pulse, exp_mov[0]);
      end
    end
    total++;
`ifdef CURSOR_AUTO_REPEAT_EN
    if (obs !== {2'd1, 2'd0, 4'd4, 1'b0}) begin
      bad++;
      $display("FAIL hold_final got=%h want=%h", obs, {2'd1, 2'd0, 4'd4, 1'b0});
    end
`else
    if (obs !== {2'd0, 2'd1, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL hold_final got=%h want=%h", obs, {2'd0, 2'd1, 4'd1, 1'b0});
    end
`endif
  endtask

  task automatic test_reset_repeat();
    do_reset();
    btn[RIGHT] = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({obs, elige_pulse} !== 10'h000) begin
      bad++;
      $display("FAIL reset_abort got=%h want=%h", {obs, elige_pulse}, 10'h000);
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({obs, elige_pulse} !== 10'h000) begin
      bad++;
      $display("FAIL reset_quiet got=%h want=%h", {obs, elige_pulse}, 10'h000);
    end
    tick();
    total++;
    if (obs !== {2'd0, 2'd1, 4'd1, 1'b1}) begin
      bad++;
      $display("FAIL held_through_reset got=%h want=%h", obs, {2'd0, 2'd1, 4'd1, 1'b1});
    end
    btn[RIGHT] = 1'b0;
    tick();
  endtask

  task automatic test_elige();
    do_reset();
    btn[ELIGE] = 1'b1;
    btn[DOWN]  = 1'b1;
    tick();
    btn = 5'b0_0000;
    tick();
    total++;
    if ({obs, elige_pulse} !== {2'd1, 2'd0, 4'd4, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL elige_with_move got=%h want=%h", {obs, elige_pulse}, {2'd1, 2'd0, 4'd4, 1'b1, 1'b1});
    end
    tick();
    pulse(ELIGE);
    total++;
    if ({obs, elige_pulse} !== {2'd1, 2'd0, 4'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL elige_alone got=%h want=%h", {obs, elige_pulse}, {2'd1, 2'd0, 4'd4, 1'b0, 1'b1});
    end
    tick();
    total++;
    if (elige_pulse !== 1'b0) begin
      bad++;
      $display("FAIL elige_width got=%b want=0", elige_pulse);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(RIGHT);
    pulse(RIGHT);
    pulse(DOWN);
    pulse(LEFT);
    total++;
    if (obs !== {2'd1, 2'd1, 4'd5, 1'b1}) begin
      bad++;
      $display("FAIL back_to_back got=%h want=%h", obs, {2'd1, 2'd1, 4'd5, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_der();
    test_wrap();
    test_saturate();
    test_priority();
    test_hold();
    test_reset_repeat();
    test_elige();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
